// File: rtl/branch_target_predictor_pkg.sv
// Shared types for the branch target predictor: direction counter encoding,
// default geometry and the counter update rule.
package branch_target_predictor_pkg;

   localparam int BTB_ENTRIES    = 64;
   localparam int BTB_PERF_WIDTH = 32;
   localparam int BTB_IDX        = $clog2(BTB_ENTRIES);
   localparam int BTB_TAGW       = 30 - BTB_IDX;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } btb_ctr_t;

   // Entry layout at the default geometry, for consumers outside the predictor.
   typedef struct packed {
      logic                valid;
      logic [BTB_TAGW-1:0] tag;
      logic [31:0]         target;
      btb_ctr_t            ctr;
   } btb_entry_t;

   function automatic btb_ctr_t ctr_step(input btb_ctr_t c, input logic taken);
      btb_ctr_t n;
      n = c;
      if (taken && c != ST)
         n = btb_ctr_t'(c + 2'd1);
      else if (!taken && c != SNT)
         n = btb_ctr_t'(c - 2'd1);
      return n;
   endfunction

endpackage

// File: rtl/branch_target_predictor_perf_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module perf_sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (inc && count != '1)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, looked up combinationally
// in IF and trained from EX, plus saturating hit/mispredict counters.
module branch_target_predictor
   import branch_target_predictor_pkg::*;
#(
   parameter int ENTRIES    = BTB_ENTRIES,
   parameter int PERF_WIDTH = BTB_PERF_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           lookup_pc,
   output logic                  predict_hit,
   output logic                  predict_taken,
   output logic [31:0]           predict_target,
   input  logic                  update_valid,
   input  logic                  pipe,
   input  logic [31:0]           update_pc,
   input  logic                  update_is_cond,
   input  logic                  update_taken,
   input  logic [31:0]           update_target,
   input  logic                  update_pred_taken,
   input  logic [31:0]           update_pred_target,
   output logic                  mispredict,
   output logic [PERF_WIDTH-1:0] hit_count,
   output logic [PERF_WIDTH-1:0] mispredict_count
);

   localparam int IDX  = $clog2(ENTRIES);
   localparam int TAGW = 30 - IDX;

   if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
      $error("branch_target_predictor: ENTRIES must be a power of 2 and >= 2");
   end

   typedef struct packed {
      logic            valid;
      logic [TAGW-1:0] tag;
      logic [31:0]     target;
      btb_ctr_t        ctr;
   } entry_t;

   entry_t btb_q [ENTRIES];

   logic [IDX-1:0]  look_idx, upd_idx;
   logic [TAGW-1:0] look_tag, upd_tag;
   logic            upd_hit;
   logic            unused_pc_bits;

   assign look_idx = lookup_pc[IDX+1:2];
   assign look_tag = lookup_pc[31:IDX+2];
   assign upd_idx  = update_pc[IDX+1:2];
   assign upd_tag  = update_pc[31:IDX+2];
   assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

   // Lookup sees registered contents only; a same-cycle update lands next cycle.
   assign predict_hit    = btb_q[look_idx].valid && (btb_q[look_idx].tag == look_tag);
   assign predict_taken  = predict_hit && btb_q[look_idx].ctr[1];
   assign predict_target = predict_hit ? btb_q[look_idx].target : 32'd0;

   assign upd_hit = btb_q[upd_idx].valid && (btb_q[upd_idx].tag == upd_tag);

   assign mispredict = update_valid &&
                       ((update_taken != update_pred_taken) ||
                        (update_taken && (update_target != update_pred_target)));

   // Tags and targets are left alone on reset; valid=0 hides them.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb_q[i].valid <= 1'b0;
            btb_q[i].ctr   <= WNT;
         end
      end else if (pipe && update_valid) begin
         if (upd_hit) begin
            if (update_is_cond) begin
               btb_q[upd_idx].ctr <= ctr_step(btb_q[upd_idx].ctr, update_taken);
               if (update_taken)
                  btb_q[upd_idx].target <= update_target;
            end else begin
               btb_q[upd_idx].ctr    <= ST;
               btb_q[upd_idx].target <= update_target;
            end
         end else if (update_taken) begin
            btb_q[upd_idx].valid  <= 1'b1;
            btb_q[upd_idx].tag    <= upd_tag;
            btb_q[upd_idx].target <= update_target;
            btb_q[upd_idx].ctr    <= update_is_cond ? WT : ST;
         end
      end
   end

   perf_sat_counter #(.WIDTH(PERF_WIDTH)) u_hit_count (
      .clk   (clk),
      .rst   (rst),
      .inc   (pipe && predict_hit),
      .count (hit_count)
   );

   perf_sat_counter #(.WIDTH(PERF_WIDTH)) u_mispredict_count (
      .clk   (clk),
      .rst   (rst),
      .inc   (pipe && mispredict),
      .count (mispredict_count)
   );

endmodule
